// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared framing constants and state encoding for the UART TX frame path
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Frame byte order, shared with the host-side decoder and the RX framer
    localparam int FRM_OFS_SYNC    = 0;
    localparam int FRM_OFS_SRC     = 1;
    localparam int FRM_OFS_PAYLOAD = 2;
    localparam int FRM_OVERHEAD    = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_SRC     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CSUM    = 3'd4
    } state_e;

    function automatic logic [7:0] src_byte(input logic [2:0] id);
        return {5'd0, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching from ptr+1 with wrap
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx
);

    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        // The requester at ptr was served last, so it is examined last
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// rtl/uart_tx_frame_arbiter.sv - round-robin framer sharing the UART TX FIFO between requesters
module uart_tx_frame_arbiter
    import uart_pkg::*;
#(
    parameter int         NUM_REQ   = 4,
    parameter int         MAX_LEN   = 255,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         ID_W      = $clog2(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_wr_en,
    output logic [7:0]           fifo_wr_data,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 frame_done,
    output logic                 len_err
);

    state_e          state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]      csum_q, csum_d;
    logic [7:0]      len_q, len_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic               any_win;

    logic       g_valid;
    logic       g_last;
    logic [7:0] g_data;
    logic [7:0] src_val;
    logic       at_limit;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (ID_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign any_win  = |arb_grant;
    assign src_val  = src_byte(3'(grant_q));
    assign at_limit = ({1'b0, len_q} + 9'd1) == 9'(MAX_LEN);
    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_q;

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        csum_d       = csum_q;
        len_d        = len_q;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = 8'h00;
        req_ready    = '0;
        frame_done   = 1'b0;
        len_err      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_win) begin
                    grant_d  = arb_idx;
                    rr_ptr_d = arb_idx;
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                fifo_wr_data = SYNC_BYTE;
                fifo_wr_en   = !fifo_full;
                if (!fifo_full) begin
                    state_d = ST_SRC;
                end
            end
            ST_SRC: begin
                fifo_wr_data = src_val;
                fifo_wr_en   = !fifo_full;
                if (!fifo_full) begin
                    csum_d  = src_val;
                    len_d   = 8'd0;
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                fifo_wr_data = g_data;
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (grant_q == ID_W'(i)) && !fifo_full;
                end
                if (g_valid && !fifo_full) begin
                    fifo_wr_en = 1'b1;
                    csum_d     = csum_q ^ g_data;
                    len_d      = len_q + 8'd1;
                    // A last byte landing exactly on the limit is a clean end, not a truncation
                    if (g_last) begin
                        state_d = ST_CSUM;
                    end else if (at_limit) begin
                        len_err = 1'b1;
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                fifo_wr_data = csum_q;
                fifo_wr_en   = !fifo_full;
                if (!fifo_full) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
            csum_q   <= 8'h00;
            len_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            csum_q   <= csum_d;
            len_q    <= len_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// tb/tb_uart_tx_frame_arbiter.sv - self-checking bench for uart_tx_frame_arbiter
module tb_uart_tx_frame_arbiter;

    localparam int NR = 4;
    localparam int ML = 4;
    localparam int IW = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NR-1:0]   req_valid;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [7:0]      fifo_wr_data;
    logic            busy;
    logic [IW-1:0]   grant_id;
    logic            frame_done;
    logic            len_err;

    always #5 clock = ~clock;

    uart_tx_frame_arbiter #(
        .NUM_REQ (NR),
        .MAX_LEN (ML)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .busy         (busy),
        .grant_id     (grant_id),
        .frame_done   (frame_done),
        .len_err      (len_err)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Requester queues: bit 8 = last flag
    typedef logic [8:0] ent_t;
    ent_t rq[NR][$];
    ent_t mq[NR][$];
    logic [NR-1:0] hold       = '0;
    logic          force_full = 1'b0;
    logic          rand_full  = 1'b0;
    logic          drv_en     = 1'b0;
    logic [NR-1:0] acc;

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        forever begin
            @(negedge clock);
            acc = req_valid & req_ready;
            @(posedge clock);
            #1;
            if (drv_en) begin
                for (int i = 0; i < NR; i++) begin
                    ent_t tmp;
                    if (acc[i] && rq[i].size() > 0) tmp = rq[i].pop_front();
                    req_valid[i]        = !hold[i] && (rq[i].size() > 0);
                    tmp                 = (rq[i].size() > 0) ? rq[i][0] : 9'h000;
                    req_data[8*i +: 8]  = tmp[7:0];
                    req_last[i]         = tmp[8];
                end
                fifo_full = force_full | (rand_full && ($urandom_range(0, 2) == 0));
            end
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       done;
        logic       lerr;
        int         c;
    } wr_t;
    typedef struct {
        logic [7:0] d;
        logic       done;
        logic       lerr;
    } ex_t;
    wr_t got[$];
    ex_t exq[$];

    always @(negedge clock) begin
        if (reset && fifo_wr_en) begin
            got.push_back('{fifo_wr_data, frame_done, len_err, cyc});
            if (fifo_full) begin
                n_bad++;
                $display("FAIL wr_while_full: got wr_en=1 expected 0 at cycle %0d", cyc);
            end
        end
    end

    task automatic load(input int r, input logic [7:0] d, input logic last, input logic to_model);
        rq[r].push_back({last, d});
        if (to_model) mq[r].push_back({last, d});
    endtask

    // Reference: drain every queued frame in round-robin order, truncating at ML bytes
    int mptr = NR - 1;
    task automatic model_run();
        forever begin
            int   w;
            int   n;
            logic fin;
            logic [7:0] cs;
            ent_t e;
            w = -1;
            for (int k = 1; k <= NR; k++) begin
                int idx;
                idx = (mptr + k) % NR;
                if (w < 0 && mq[idx].size() > 0) w = idx;
            end
            if (w < 0) break;
            mptr = w;
            cs   = 8'(w);
            exq.push_back('{8'hA5, 1'b0, 1'b0});
            exq.push_back('{8'(w), 1'b0, 1'b0});
            n   = 0;
            fin = 1'b0;
            while (!fin && mq[w].size() > 0) begin
                e  = mq[w].pop_front();
                n++;
                cs = cs ^ e[7:0];
                exq.push_back('{e[7:0], 1'b0, (!e[8] && n == ML)});
                fin = e[8] || (n == ML);
            end
            exq.push_back('{cs, 1'b1, 1'b0});
        end
    endtask

    task automatic wait_got(input string tag, input int n);
        for (int t = 0; t < 3000 && got.size() < n; t++) begin
            @(negedge clock);
            #1;
        end
        chk({tag, "_wait"}, got.size() >= n, 1'b1);
    endtask

    task automatic compare_stream(input string tag);
        wait_got(tag, exq.size());
        repeat (4) begin
            @(negedge clock);
            #1;
        end
        chk({tag, "_count"}, got.size(), exq.size());
        for (int i = 0; i < exq.size() && i < got.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), got[i].d, exq[i].d);
            chk($sformatf("%s_flags%0d", tag, i), {got[i].done, got[i].lerr}, {exq[i].done, exq[i].lerr});
            if (i > 0 && got[i-1].done)
                chk($sformatf("%s_gap%0d", tag, i), (got[i].c - got[i-1].c) >= 2, 1'b1);
        end
    endtask

    task automatic clear_stream();
        got.delete();
        exq.delete();
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    function automatic int count_lerr();
        int n = 0;
        foreach (got[i]) if (got[i].lerr) n++;
        return n;
    endfunction

    typedef struct {
        logic [NR-1:0] v;
        logic [7:0]    d1;
        logic          l1;
        logic          wr;
        logic [7:0]    wd;
        logic          dn;
        logic          bsy;
        logic [NR-1:0] rdy;
        logic [IW-1:0] gid;
    } vec_t;
    vec_t tbl[8];

    initial begin
        // single frame from requester 1: A5 01 10 22 33 on consecutive cycles
        tbl[0] = '{4'b0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 2'd0};
        tbl[1] = '{4'b0010, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 2'd0};
        tbl[2] = '{4'b0010, 8'h10, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 4'b0000, 2'd1};
        tbl[3] = '{4'b0010, 8'h10, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 4'b0000, 2'd1};
        tbl[4] = '{4'b0010, 8'h10, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 4'b0010, 2'd1};
        tbl[5] = '{4'b0010, 8'h22, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 4'b0010, 2'd1};
        tbl[6] = '{4'b0000, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 4'b0000, 2'd1};
        tbl[7] = '{4'b0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 2'd1};

        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs", {fifo_wr_en, fifo_wr_data, busy, grant_id, frame_done, len_err, req_ready}, '0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            req_valid       = tbl[i].v;
            req_data        = '0;
            req_data[15:8]  = tbl[i].d1;
            req_last        = {2'b00, tbl[i].l1, 1'b0};
            fifo_full       = 1'b0;
            #5;
            chk($sformatf("tbl%0d_wr_en", i), fifo_wr_en, tbl[i].wr);
            chk($sformatf("tbl%0d_wr_data", i), fifo_wr_data, tbl[i].wd);
            chk($sformatf("tbl%0d_done", i), frame_done, tbl[i].dn);
            chk($sformatf("tbl%0d_len_err", i), len_err, 1'b0);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_grant", i), grant_id, tbl[i].gid);
        end
        mptr   = 1;
        drv_en = 1'b1;
        tick();
        clear_stream();

        // backpressure and requester stall during PAYLOAD
        load(2, 8'h5A, 1'b0, 1'b1);
        load(2, 8'h3C, 1'b0, 1'b1);
        load(2, 8'h0F, 1'b1, 1'b1);
        model_run();
        wait_got("bp", 3);
        force_full = 1'b1;
        tick();
        repeat (5) begin
            tick();
            chk("bp_stall_wr", fifo_wr_en, 1'b0);
            chk("bp_stall_ready", req_ready, 4'b0000);
        end
        force_full = 1'b0;
        hold[2]    = 1'b1;
        tick();
        repeat (3) begin
            tick();
            chk("stall_wr", fifo_wr_en, 1'b0);
            chk("stall_busy", busy, 1'b1);
        end
        hold[2] = 1'b0;
        compare_stream("bp");
        chk("bp_csum", got[got.size()-1].d, 8'h02 ^ 8'h5A ^ 8'h3C ^ 8'h0F);
        clear_stream();

        // round-robin between requesters 0 and 2
        load(0, 8'h11, 1'b1, 1'b1);
        load(0, 8'h12, 1'b1, 1'b1);
        load(2, 8'h21, 1'b1, 1'b1);
        load(2, 8'h22, 1'b1, 1'b1);
        model_run();
        compare_stream("rr");
        if (got.size() >= 16) begin
            chk("rr_order", {got[1].d, got[5].d, got[9].d, got[13].d}, 32'h00020002);
        end else begin
            chk("rr_order_len", got.size(), 16);
        end
        clear_stream();

        // truncation: six bytes, last only on the sixth
        for (int b = 1; b <= 6; b++) load(0, 8'(b), (b == 6), 1'b1);
        model_run();
        compare_stream("trunc");
        chk("trunc_lerr_cnt", count_lerr(), 1);
        if (got.size() > 5) chk("trunc_lerr_pos", got[5].lerr, 1'b1);
        clear_stream();

        // last byte exactly at the limit
        for (int b = 0; b < 4; b++) load(3, 8'h40 + 8'(b), (b == 3), 1'b1);
        model_run();
        compare_stream("atlim");
        chk("atlim_lerr_cnt", count_lerr(), 0);
        clear_stream();

        // reset in the middle of a frame
        load(1, 8'h77, 1'b0, 1'b0);
        load(1, 8'h78, 1'b0, 1'b0);
        load(1, 8'h79, 1'b1, 1'b0);
        wait_got("rst", 3);
        reset = 1'b0;
        #1;
        chk("rst_mid_outputs", {fifo_wr_en, fifo_wr_data, busy, grant_id, frame_done, len_err, req_ready}, '0);
        for (int i = 0; i < NR; i++) begin
            rq[i].delete();
            mq[i].delete();
        end
        @(negedge clock);
        reset = 1'b1;
        clear_stream();
        mptr = NR - 1;
        tick();
        load(0, 8'hC0, 1'b1, 1'b1);
        load(3, 8'hC3, 1'b1, 1'b1);
        model_run();
        compare_stream("rst");
        if (got.size() > 1) chk("rst_first_grant", got[1].d, 8'h00);
        clear_stream();

        // randomized traffic with random FIFO backpressure
        rand_full = 1'b1;
        for (int round = 0; round < 4; round++) begin
            for (int r = 0; r < NR; r++) begin
                int nfr;
                nfr = $urandom_range(0, 3);
                for (int f = 0; f < nfr; f++) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++)
                        load(r, 8'($urandom), (b == len - 1), 1'b1);
                end
            end
            model_run();
            compare_stream($sformatf("rand%0d", round));
            clear_stream();
        end
        rand_full = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
